// File: rtl/rgb_fade_grey.sv
// Colour output stage: blanking, greyscale conversion, shadow/highlight pin
// generation and a frame-stepped brightness fade, through a 2-stage pipeline.
module rgb_fade_grey #(
  parameter int CW          = 5,
  parameter int FW          = 4,
  parameter int RW          = 4,
  parameter int RESET_LEVEL = 2**FW - 1
) (
  input  logic          CLK,
  input  logic          nRESET,
  input  logic          nBLANK,
  input  logic          nGREY,
  input  logic          nSHADE,
  input  logic          HI_LO,
  input  logic [CW-1:0] R,
  input  logic [CW-1:0] G,
  input  logic [CW-1:0] B,
  input  logic          VSYNC_PULSE,
  input  logic          FADE_START,
  input  logic [FW-1:0] FADE_TARGET,
  input  logic [RW-1:0] FADE_RATE,
  output logic [CW-1:0] ROUT,
  output logic [CW-1:0] GOUT,
  output logic [CW-1:0] BOUT,
  output logic [2:0]    SH_D,
  output logic [2:0]    nSH_EN,
  output logic [FW-1:0] FADE_LEVEL,
  output logic          FADE_BUSY
);

  typedef enum logic {S_IDLE, S_WAIT} fade_state_e;

  // Scale one channel by (level+1)/2^FW; level 0 forces black.
  function automatic logic [CW-1:0] fade_ch(input logic [CW-1:0] c,
                                            input logic [FW-1:0] l);
    logic [CW+FW:0] prod;
    prod = (CW+FW+1)'(c) * ((CW+FW+1)'(l) + (CW+FW+1)'(1));
    return (l == '0) ? '0 : CW'(prod >> FW);
  endfunction

  // Stage 1: colour select and qualifiers
  logic [CW+1:0] grey_sum;
  logic [CW-1:0] grey_val;
  logic [CW-1:0] s1_r_d, s1_g_d, s1_b_d, s1_r_q, s1_g_q, s1_b_q;
  logic          s1_blank_n_q, s1_shade_n_q, s1_hilo_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grey_sum = (CW+2)'(R) + ((CW+2)'(G) << 1) + (CW+2)'(B);
    grey_val = CW'(grey_sum >> 2);
    s1_r_d   = R;
    s1_g_d   = G;
    s1_b_d   = B;
    if (!nBLANK) begin
      s1_r_d = '0;
      s1_g_d = '0;
      s1_b_d = '0;
    end else if (!nGREY) begin
      s1_r_d = grey_val;
      s1_g_d = grey_val;
      s1_b_d = grey_val;
    end
  end

  // Stage 2: fade and shadow/highlight pins
  logic [FW-1:0] level_q, level_d;
  logic [CW-1:0] rout_d, gout_d, bout_d, rout_q, gout_q, bout_q;
  logic [2:0]    nz;
  logic [2:0]    sh_d_d, sh_d_q, sh_en_n_d, sh_en_n_q;

  always_comb begin
    rout_d    = fade_ch(s1_r_q, level_q);
    gout_d    = fade_ch(s1_g_q, level_q);
    bout_d    = fade_ch(s1_b_q, level_q);
    nz        = {|bout_d, |gout_d, |rout_d};
    sh_d_d    = ~({3{s1_hilo_q & s1_blank_n_q}} & nz);
    sh_en_n_d = ~({3{~s1_shade_n_q & s1_blank_n_q}} & nz);
  end

  // NOTE: pipeline registers are reset (blank flag asserted) so the pins are
  // released and the colour is black from the first cycle out of reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      s1_r_q       <= '0;
      s1_g_q       <= '0;
      s1_b_q       <= '0;
      s1_blank_n_q <= 1'b0;
      s1_shade_n_q <= 1'b1;
      s1_hilo_q    <= 1'b0;
      rout_q       <= '0;
      gout_q       <= '0;
      bout_q       <= '0;
      sh_d_q       <= 3'b111;
      sh_en_n_q    <= 3'b111;
    end else begin
      s1_r_q       <= s1_r_d;
      s1_g_q       <= s1_g_d;
      s1_b_q       <= s1_b_d;
      s1_blank_n_q <= nBLANK;
      s1_shade_n_q <= nSHADE;
      s1_hilo_q    <= HI_LO;
      rout_q       <= rout_d;
      gout_q       <= gout_d;
      bout_q       <= bout_d;
      sh_d_q       <= sh_d_d;
      sh_en_n_q    <= sh_en_n_d;
    end
  end

  // Fade engine: state register
  fade_state_e   state_q, state_d;
  logic [FW-1:0] target_q, target_d;
  logic [RW-1:0] rate_q, rate_d, cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= S_IDLE;
      level_q  <= FW'(RESET_LEVEL);
      target_q <= FW'(RESET_LEVEL);
      rate_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      rate_q   <= rate_d;
      cnt_q    <= cnt_d;
    end
  end

  // Fade engine: next state. A start pulse takes priority over a vsync.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    target_d = target_q;
    rate_d   = rate_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (FADE_START) begin
          rate_d = FADE_RATE;
          if (FADE_TARGET != level_q) begin
            target_d = FADE_TARGET;
            cnt_d    = FADE_RATE;
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (FADE_START) begin
          target_d = FADE_TARGET;
          rate_d   = FADE_RATE;
          cnt_d    = FADE_RATE;
          state_d  = (FADE_TARGET == level_q) ? S_IDLE : S_WAIT;
        end else if (VSYNC_PULSE) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - RW'(1);
          end else begin
            // Stepping toward the target can never overshoot, so no wrap.
            level_d = (level_q < target_q) ? level_q + FW'(1) : level_q - FW'(1);
            cnt_d   = rate_q;
            if (level_d == target_q) state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fade engine: outputs
  always_comb begin
    FADE_BUSY  = (state_q == S_WAIT);
    FADE_LEVEL = level_q;
  end

  assign ROUT   = rout_q;
  assign GOUT   = gout_q;
  assign BOUT   = bout_q;
  assign SH_D   = sh_d_q;
  assign nSH_EN = sh_en_n_q;

endmodule

// File: tb/tb_rgb_fade_grey.sv
// Scoreboard bench for rgb_fade_grey: a driver pushes expected results from a
// behavioural model, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_rgb_fade_grey;
  localparam int CW   = 5;
  localparam int FW   = 4;
  localparam int RW   = 4;
  localparam int MAXL = 2**FW - 1;

  logic          CLK = 1'b0;
  logic          nRESET = 1'b0;
  logic          nBLANK, nGREY, nSHADE, HI_LO;
  logic [CW-1:0] R, G, B;
  logic          VSYNC_PULSE, FADE_START;
  logic [FW-1:0] FADE_TARGET;
  logic [RW-1:0] FADE_RATE;
  logic [CW-1:0] ROUT, GOUT, BOUT;
  logic [2:0]    SH_D, nSH_EN;
  logic [FW-1:0] FADE_LEVEL;
  logic          FADE_BUSY;

  rgb_fade_grey #(.CW(CW), .FW(FW), .RW(RW)) dut (
    .CLK(CLK), .nRESET(nRESET), .nBLANK(nBLANK), .nGREY(nGREY),
    .nSHADE(nSHADE), .HI_LO(HI_LO), .R(R), .G(G), .B(B),
    .VSYNC_PULSE(VSYNC_PULSE), .FADE_START(FADE_START),
    .FADE_TARGET(FADE_TARGET), .FADE_RATE(FADE_RATE),
    .ROUT(ROUT), .GOUT(GOUT), .BOUT(BOUT), .SH_D(SH_D), .nSH_EN(nSH_EN),
    .FADE_LEVEL(FADE_LEVEL), .FADE_BUSY(FADE_BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {int r; int g; int b; bit blank_n; bit grey_n; bit shade_n; bit hilo;} pix_t;
  typedef struct {int r; int g; int b; int sh_d; int nsh_en;} exp_pix_t;
  typedef struct {int level; bit busy;} exp_fade_t;

  exp_pix_t  q_pix[$];
  exp_fade_t q_fade[$];
  int        n_cmp = 0;
  int        n_err = 0;
  bit        issue = 1'b0;
  logic [1:0] vld;

  // Reference fade state, advanced once per clock from the same inputs
  int m_level, m_target, m_rate, m_cnt;
  bit m_busy;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_pix_t model_pix(input pix_t p, input int lvl);
    exp_pix_t e;
    int in_c[3];
    int out_c[3];
    int base, f;
    in_c = '{p.r, p.g, p.b};
    e.sh_d = 0;
    e.nsh_en = 0;
    for (int i = 0; i < 3; i++) begin
      if (!p.blank_n)     base = 0;
      else if (!p.grey_n) base = (p.r + 2*p.g + p.b) / 4;
      else                base = in_c[i];
      f = (lvl == 0) ? 0 : (base * (lvl + 1)) / (2**FW);
      out_c[i] = f;
      if (!(p.hilo && p.blank_n && f != 0))     e.sh_d   |= (1 << i);
      if (!(!p.shade_n && p.blank_n && f != 0)) e.nsh_en |= (1 << i);
    end
    e.r = out_c[0];
    e.g = out_c[1];
    e.b = out_c[2];
    return e;
  endfunction

  function automatic pix_t rand_pix();
    pix_t p;
    p.r       = $urandom_range(0, 2**CW-1);
    p.g       = $urandom_range(0, 2**CW-1);
    p.b       = $urandom_range(0, 2**CW-1);
    p.blank_n = ($urandom_range(0, 7) != 0);
    p.grey_n  = ($urandom_range(0, 3) != 0);
    p.shade_n = $urandom_range(0, 1);
    p.hilo    = $urandom_range(0, 1);
    return p;
  endfunction

  // One pixel/fade-control cycle: drive, advance the model, push expectations.
  task automatic step(input bit start, input int tgt, input int rate, input bit vs, input pix_t p);
    @(posedge CLK); #1;
    FADE_START  = start;
    FADE_TARGET = FW'(tgt);
    FADE_RATE   = RW'(rate);
    VSYNC_PULSE = vs;
    R = CW'(p.r); G = CW'(p.g); B = CW'(p.b);
    nBLANK = p.blank_n; nGREY = p.grey_n; nSHADE = p.shade_n; HI_LO = p.hilo;
    issue = 1'b1;
    if (start) begin
      m_rate   = rate;
      m_target = tgt;
      m_cnt    = rate;
      m_busy   = (tgt != m_level);
    end else if (m_busy && vs) begin
      if (m_cnt > 0) m_cnt--;
      else begin
        m_level += (m_target > m_level) ? 1 : -1;
        m_cnt = m_rate;
        if (m_level == m_target) m_busy = 1'b0;
      end
    end
    q_fade.push_back('{m_level, m_busy});
    q_pix.push_back(model_pix(p, m_level));
  endtask

  task automatic do_reset();
    @(negedge CLK); #2;
    issue = 1'b0;
    FADE_START = 1'b0;
    VSYNC_PULSE = 1'b0;
    nRESET = 1'b0;
    #1;
    q_pix.delete();
    q_fade.delete();
    m_level = MAXL; m_target = MAXL; m_rate = 0; m_cnt = 0; m_busy = 1'b0;
    check("rst_ROUT", int'(ROUT), 0);
    check("rst_GOUT", int'(GOUT), 0);
    check("rst_BOUT", int'(BOUT), 0);
    check("rst_SH_D", int'(SH_D), 7);
    check("rst_nSH_EN", int'(nSH_EN), 7);
    check("rst_FADE_LEVEL", int'(FADE_LEVEL), MAXL);
    check("rst_FADE_BUSY", int'(FADE_BUSY), 0);
    repeat (2) @(negedge CLK);
    #2 nRESET = 1'b1;
  endtask

  always @(posedge CLK or negedge nRESET) begin
    if (!nRESET) vld <= 2'b00;
    else         vld <= {vld[0], issue};
  end

  // Monitor: fade state is due 1 cycle after issue, pixels 2 cycles after.
  always @(negedge CLK) begin : monitor
    exp_fade_t ef;
    exp_pix_t  ep;
    if (nRESET) begin
      if (vld[0]) begin
        if (q_fade.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL fade_queue: empty when DUT state was due at %0t", $time);
        end else begin
          ef = q_fade.pop_front();
          check("FADE_LEVEL", int'(FADE_LEVEL), ef.level);
          check("FADE_BUSY", int'(FADE_BUSY), int'(ef.busy));
        end
      end
      if (vld[1]) begin
        if (q_pix.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL pix_queue: empty when DUT pixel was due at %0t", $time);
        end else begin
          ep = q_pix.pop_front();
          check("ROUT", int'(ROUT), ep.r);
          check("GOUT", int'(GOUT), ep.g);
          check("BOUT", int'(BOUT), ep.b);
          check("SH_D", int'(SH_D), ep.sh_d);
          check("nSH_EN", int'(nSH_EN), ep.nsh_en);
        end
      end
    end
  end

  initial begin : driver
    pix_t p;
    int   guard;
    nBLANK = 1'b1; nGREY = 1'b1; nSHADE = 1'b1; HI_LO = 1'b0;
    R = '0; G = '0; B = '0;
    VSYNC_PULSE = 1'b0; FADE_START = 1'b0; FADE_TARGET = '0; FADE_RATE = '0;
    do_reset();

    // Directed pixels at full brightness: passthrough, grey, grey saturated, blank
    step(0, 0, 0, 0, '{31, 10, 0, 1'b1, 1'b1, 1'b0, 1'b1});
    step(0, 0, 0, 0, '{8, 20, 4, 1'b1, 1'b0, 1'b1, 1'b0});
    step(0, 0, 0, 0, '{31, 31, 31, 1'b1, 1'b0, 1'b1, 1'b0});
    step(0, 0, 0, 0, '{31, 31, 31, 1'b0, 1'b1, 1'b0, 1'b1});
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, rand_pix());

    // Fade 15 -> 0 at rate 1: one step every second vsync, 30 pulses total
    step(1, 0, 1, 0, rand_pix());
    for (int i = 0; i < 30; i++) begin
      p = rand_pix();
      if (i % 2 == 0) begin p.r = 31; p.blank_n = 1'b1; p.grey_n = 1'b1; end
      step(0, 0, 0, 1, p);
      step(0, 0, 0, 0, rand_pix());
      step(0, 0, 0, 0, '{31, 31, 31, 1'b1, 1'b1, 1'b0, 1'b1});
    end
    @(negedge CLK);
    check("fade_end_level", int'(FADE_LEVEL), 0);
    check("fade_end_busy", int'(FADE_BUSY), 0);

    // Rise to 9, then fade down and retarget to 12 at level 5 together with a vsync
    step(1, 9, 0, 0, rand_pix());
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, rand_pix());
    step(1, 0, 1, 0, rand_pix());
    guard = 0;
    while (m_level != 5 && guard < 100) begin
      step(0, 0, 0, 1, rand_pix());
      guard++;
    end
    if (guard >= 100) check("reach_level5_timeout", m_level, 5);
    step(1, 12, 1, 1, rand_pix());
    guard = 0;
    while (m_busy && guard < 200) begin
      step(0, 0, 0, guard % 2 == 0, rand_pix());
      guard++;
    end
    if (guard >= 200) check("retarget_timeout", int'(m_busy), 0);
    repeat (2) step(0, 0, 0, 0, rand_pix());
    @(negedge CLK);
    check("retarget_level", int'(FADE_LEVEL), 12);
    check("retarget_busy", int'(FADE_BUSY), 0);

    // Random traffic with occasional starts, retargets and vsync collisions
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, MAXL), $urandom_range(0, 3),
           $urandom_range(0, 2) == 0, rand_pix());

    // Reset in the middle of a fade
    step(1, 0, 0, 0, rand_pix());
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, rand_pix());
    do_reset();
    for (int i = 0; i < 20; i++) step(0, 0, 0, $urandom_range(0, 1), rand_pix());

    @(posedge CLK); #1 issue = 1'b0;
    repeat (3) @(negedge CLK);
    check("pix_queue_drained", q_pix.size(), 0);
    check("fade_queue_drained", q_fade.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
